// File: rtl/pico_mcb_bridge.sv
// pico_mcb_bridge: KCPSM6 port-mapped bridge to one Spartan-6 MCB user port.
// Firmware stages write words and programs ADDR/BL through I/O registers.
// A small sequencer drives the MCB command and read-FIFO handshakes.
module pico_mcb_bridge #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 30,
    parameter logic [7:0]  PORT_BASE = 8'h20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            port_id,
    input  logic [7:0]            out_port,
    input  logic                  write_strobe,
    input  logic                  read_strobe,
    output logic [7:0]            in_port,
    input  logic                  ddr_calib_done,
    output logic                  cmd_en,
    output logic [2:0]            cmd_instr,
    output logic [5:0]            cmd_bl,
    output logic [ADDR_W-1:0]     cmd_byte_addr,
    input  logic                  cmd_full,
    output logic                  wr_en,
    output logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W/8-1:0]   wr_mask,
    input  logic                  wr_full,
    input  logic                  wr_empty,
    output logic                  rd_en,
    input  logic [DATA_W-1:0]     rd_data,
    input  logic                  rd_empty
);

    localparam int unsigned NB       = DATA_W / 8;
    localparam logic [7:0] OFF_BL     = 8'd4;
    localparam logic [7:0] OFF_LANE   = 8'd8;
    localparam logic [7:0] OFF_TOP    = 8'(8 + NB - 1);
    localparam logic [7:0] OFF_CTRL   = 8'd12;
    localparam logic [7:0] OFF_STATUS = 8'd13;
    localparam logic [7:0] OFF_WCNT   = 8'd14;
    localparam logic [7:0] OFF_RREM   = 8'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_CMD,
        S_RD_CMD,
        S_RD_FETCH,
        S_RD_HOLD
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] addr;
    logic [5:0]        bl;
    logic [DATA_W-1:0] stage;
    logic [DATA_W-1:0] hold;
    logic [6:0]        wr_cnt;
    logic [6:0]        rd_rem;
    logic              valid;
    logic              err;

    logic [7:0]        off;
    logic              hit, wr_hit, ctrl_wr;
    logic              start_wr, start_rd, start_both, pop, clr_err;
    logic              commit, commit_ok, addr_wr;
    logic [6:0]        burst_words;
    logic [ADDR_W-1:0] addr_step;
    logic [31:0]       addr_cur, addr_new;
    logic [DATA_W-1:0] commit_word;
    logic [7:0]        rd_mux;
    logic              issue_wr, issue_rd, fetch, done_rd, fsm_err;

    // Register decode; subtraction wraps so a single compare bounds the window
    assign off         = port_id - PORT_BASE;
    assign hit         = off < 8'd16;
    assign wr_hit      = write_strobe && hit;
    assign ctrl_wr     = wr_hit && (off == OFF_CTRL);
    assign start_wr    = ctrl_wr && out_port[0] && !out_port[1];
    assign start_rd    = ctrl_wr && out_port[1] && !out_port[0];
    assign start_both  = ctrl_wr && out_port[0] && out_port[1];
    assign pop         = ctrl_wr && out_port[2];
    assign clr_err     = ctrl_wr && out_port[7];
    assign commit      = wr_hit && (off == OFF_TOP);
    assign commit_ok   = commit && !wr_full;
    assign addr_wr     = wr_hit && (off < 8'd4);
    assign burst_words = 7'(bl) + 7'd1;
    assign addr_step   = ADDR_W'(32'(burst_words) * NB);
    assign addr_cur    = 32'(addr);
    assign wr_mask     = '0;
    assign rd_en       = fetch;

    // Staged word with the top lane taken straight from the committing write
    always_comb begin
        commit_word = stage;
        commit_word[DATA_W-8 +: 8] = out_port;
    end

    // ADDR with the addressed byte replaced
    always_comb begin
        addr_new = addr_cur;
        for (int unsigned i = 0; i < 4; i++) begin
            if (off == 8'(i)) addr_new[8*i +: 8] = out_port;
        end
    end

    // Read-back multiplexer
    always_comb begin
        rd_mux = 8'h00;
        if (hit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (off == 8'(i)) rd_mux = addr_cur[8*i +: 8];
            end
            for (int unsigned i = 0; i < NB; i++) begin
                if (off == 8'(8 + i)) rd_mux = hold[8*i +: 8];
            end
            if (off == OFF_STATUS)
                rd_mux = {1'b0, cmd_full, wr_empty, err, valid, wr_full,
                          ddr_calib_done, state != S_IDLE};
            if (off == OFF_WCNT) rd_mux = {1'b0, wr_cnt};
            if (off == OFF_RREM) rd_mux = {1'b0, rd_rem};
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Sequencer next state and strobes
    always_comb begin
        state_nx = state;
        issue_wr = 1'b0;
        issue_rd = 1'b0;
        fetch    = 1'b0;
        done_rd  = 1'b0;
        fsm_err  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_wr) begin
                    if (ddr_calib_done && wr_cnt == burst_words) state_nx = S_WR_CMD;
                    else                                          fsm_err  = 1'b1;
                end else if (start_rd) begin
                    if (ddr_calib_done) state_nx = S_RD_CMD;
                    else                fsm_err  = 1'b1;
                end
            end
            S_WR_CMD: begin
                if (!cmd_full) begin
                    issue_wr = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_RD_CMD: begin
                if (!cmd_full) begin
                    issue_rd = 1'b1;
                    state_nx = S_RD_FETCH;
                end
            end
            S_RD_FETCH: begin
                if (!rd_empty && !valid) begin
                    fetch    = 1'b1;
                    state_nx = S_RD_HOLD;
                end
            end
            S_RD_HOLD: begin
                if (pop) begin
                    if (rd_rem != 7'd0) begin
                        state_nx = S_RD_FETCH;
                    end else begin
                        done_rd  = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (state != S_IDLE && (start_wr || start_rd)) fsm_err = 1'b1;
        if (start_both || (pop && !valid))             fsm_err = 1'b1;
    end

    // Datapath registers, MCB command/write outputs and read-back
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr          <= '0;
            bl            <= '0;
            stage         <= '0;
            hold          <= '0;
            wr_cnt        <= '0;
            rd_rem        <= '0;
            valid         <= 1'b0;
            err           <= 1'b0;
            in_port       <= '0;
            cmd_en        <= 1'b0;
            cmd_instr     <= 3'b000;
            cmd_bl        <= '0;
            cmd_byte_addr <= '0;
            wr_en         <= 1'b0;
            wr_data       <= '0;
        end else begin
            in_port <= rd_mux;
            wr_en   <= 1'b0;
            cmd_en  <= 1'b0;

            if (wr_hit && off == OFF_BL) bl <= out_port[5:0];
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_hit && off == 8'(8 + i)) stage[8*i +: 8] <= out_port;
            end

            if (commit_ok) begin
                wr_en   <= 1'b1;
                wr_data <= commit_word;
            end
            if (issue_wr)                           wr_cnt <= commit_ok ? 7'd1 : 7'd0;
            else if (commit_ok && wr_cnt != 7'd64) wr_cnt <= wr_cnt + 7'd1;

            if (issue_wr || issue_rd) begin
                cmd_en        <= 1'b1;
                cmd_instr     <= issue_rd ? 3'b001 : 3'b000;
                cmd_bl        <= bl;
                cmd_byte_addr <= addr;
            end
            if (issue_wr || done_rd) addr <= addr + addr_step;
            if (addr_wr)             addr <= ADDR_W'(addr_new);

            if (issue_rd) rd_rem <= burst_words;
            if (fetch) begin
                hold   <= rd_data;
                valid  <= 1'b1;
                rd_rem <= rd_rem - 7'd1;
            end else if (pop && valid) begin
                valid <= 1'b0;
            end

            if (clr_err)                                err <= 1'b0;
            if (fsm_err || (commit && wr_full))         err <= 1'b1;
        end
    end

    // read_strobe carries no side effect here; ADDR bits above ADDR_W are dropped
    logic unused_ok;
    assign unused_ok = ^{read_strobe, addr_new};

endmodule

// File: tb/tb_pico_mcb_bridge.sv
// Bench for pico_mcb_bridge: MCB FIFO/command model plus firmware-level tasks.
module tb_pico_mcb_bridge;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 30;
    localparam int unsigned NB     = 4;
    localparam logic [7:0]  BASE   = 8'h20;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [7:0]        port_id = 8'h00, out_port = 8'h00, in_port;
    logic              write_strobe = 1'b0, read_strobe = 1'b0;
    logic              ddr_calib_done = 1'b0;
    logic              cmd_en, cmd_full = 1'b0;
    logic [2:0]        cmd_instr;
    logic [5:0]        cmd_bl;
    logic [ADDR_W-1:0] cmd_byte_addr;
    logic              wr_en, wr_full = 1'b0, wr_empty = 1'b1;
    logic [DATA_W-1:0] wr_data;
    logic [NB-1:0]     wr_mask;
    logic              rd_en, rd_empty;
    logic [DATA_W-1:0] rd_data;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [2:0]  instr;
        logic [5:0]  bl;
        logic [29:0] addr;
    } cmd_t;

    logic [31:0] wq[$];
    cmd_t        cq[$];
    logic [31:0] rdq[$];
    logic        took = 1'b0;
    logic        rd_empty_r = 1'b1;
    logic [31:0] rd_data_r = '0;

    assign rd_empty = rd_empty_r;
    assign rd_data  = rd_data_r;

    always #5 clk = ~clk;

    pico_mcb_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PORT_BASE(BASE)) dut (
        .clk(clk), .reset(reset),
        .port_id(port_id), .out_port(out_port), .write_strobe(write_strobe),
        .read_strobe(read_strobe), .in_port(in_port),
        .ddr_calib_done(ddr_calib_done),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
        .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
        .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_full(wr_full), .wr_empty(wr_empty),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty)
    );

    // MCB side: capture write words and commands, note read-FIFO pops
    always @(posedge clk) begin
        if (wr_en)  wq.push_back(wr_data);
        if (cmd_en) cq.push_back({cmd_instr, cmd_bl, cmd_byte_addr});
        took <= rd_en;
    end

    // Read FIFO model: first-word-fall-through, advances after a pop
    always @(negedge clk) begin
        if (took && rdq.size() != 0) void'(rdq.pop_front());
        rd_empty_r = (rdq.size() == 0);
        rd_data_r  = (rdq.size() != 0) ? rdq[0] : 32'h0;
    end

    function automatic logic [29:0] next_addr(input logic [29:0] a, input int b);
        return a + 30'((b + 1) * 4);
    endfunction

    function automatic logic [7:0] exp_status(input logic busy, input logic vld, input logic e);
        return {1'b0, cmd_full, wr_empty, e, vld, wr_full, ddr_calib_done, busy};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic io_wr(input int o, input logic [7:0] d);
        @(negedge clk);
        port_id = BASE + 8'(o); out_port = d; write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0; port_id = 8'h00;
    endtask

    task automatic io_rd(input int o, output logic [7:0] d);
        @(negedge clk);
        port_id = BASE + 8'(o); read_strobe = 1'b1;
        @(negedge clk);
        d = in_port; read_strobe = 1'b0; port_id = 8'h00;
    endtask

    task automatic set_addr(input logic [29:0] a);
        logic [31:0] w;
        w = {2'b11, a};
        for (int i = 0; i < 4; i++) io_wr(i, w[8*i +: 8]);
    endtask

    task automatic get_addr(output logic [31:0] a);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            io_rd(i, b);
            a[8*i +: 8] = b;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) io_wr(8 + i, w[8*i +: 8]);
    endtask

    task automatic wait_cmd();
        for (int t = 0; t < 40 && cq.size() == 0; t++) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] s;
        logic [31:0] a;
        idle(3);
        total++;
        if ({cmd_en, wr_en, rd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_data, wr_mask, in_port} !== '0)
            $display("FAIL reset_outputs: got cmd_en=%b wr_en=%b rd_en=%b instr=%b bl=%h addr=%h in=%h, need all 0",
                     cmd_en, wr_en, rd_en, cmd_instr, cmd_bl, cmd_byte_addr, in_port);
        else passed++;
        reset = 1'b1;
        io_rd(13, s);
        total++;
        if (s !== 8'h20) $display("FAIL reset_status: got %h need 20", s); else passed++;
        get_addr(a);
        total++;
        if (a !== 32'h0) $display("FAIL reset_addr: got %h need 0", a); else passed++;
    endtask

    task automatic test_calib();
        logic [7:0] s;
        io_wr(4, 8'd0);
        io_wr(12, 8'h02);
        idle(5);
        total++;
        if (cq.size() != 0) $display("FAIL nocalib_cmd: got %0d cmds need 0", cq.size()); else passed++;
        io_rd(13, s);
        total++;
        if (s !== exp_status(1'b0, 1'b0, 1'b1)) $display("FAIL nocalib_err: status %h need %h", s, exp_status(1'b0, 1'b0, 1'b1));
        else passed++;
        ddr_calib_done = 1'b1;
        io_wr(12, 8'h80);
        io_rd(13, s);
        total++;
        if (s !== exp_status(1'b0, 1'b0, 1'b0)) $display("FAIL clr_err: status %h need %h", s, exp_status(1'b0, 1'b0, 1'b0));
        else passed++;
        cq.delete();
    endtask

    task automatic test_write_burst(input logic [29:0] a, input int b, input logic directed);
        logic [31:0] words[$];
        logic [31:0] ra;
        logic [7:0]  s;
        for (int i = 0; i <= b; i++)
            words.push_back(directed ? (32'h11223344 + 32'(i) * 32'h44444444) : $urandom);
        wq.delete(); cq.delete();
        set_addr(a);
        io_wr(4, 8'(b) | 8'hC0);
        foreach (words[i]) push_word(words[i]);
        idle(2);
        total++;
        if (wq.size() != b + 1) $display("FAIL wr_pulses: got %0d need %0d", wq.size(), b + 1);
        else passed++;
        for (int i = 0; i <= b && i < wq.size(); i++) begin
            total++;
            if (wq[i] !== words[i]) $display("FAIL wr_word%0d: got %h need %h", i, wq[i], words[i]);
            else passed++;
        end
        io_rd(14, s);
        total++;
        if (s !== 8'(b + 1)) $display("FAIL wr_cnt: got %0d need %0d", s, b + 1); else passed++;
        io_wr(12, 8'h01);
        wait_cmd();
        idle(2);
        total++;
        if (cq.size() != 1) $display("FAIL wr_cmd_count: got %0d need 1", cq.size());
        else if (cq[0] !== {3'b000, 6'(b), a})
            $display("FAIL wr_cmd: got instr=%b bl=%0d addr=%h need 000 %0d %h", cq[0].instr, cq[0].bl, cq[0].addr, b, a);
        else passed++;
        get_addr(ra);
        total++;
        if (ra !== {2'b00, next_addr(a, b)}) $display("FAIL wr_addr_adv: got %h need %h", ra, next_addr(a, b));
        else passed++;
        io_rd(13, s);
        total++;
        if (s !== exp_status(1'b0, 1'b0, 1'b0)) $display("FAIL wr_done_status: got %h need %h", s, exp_status(1'b0, 1'b0, 1'b0));
        else passed++;
    endtask

    task automatic test_read_burst(input int b, input logic directed);
        logic [29:0] a;
        logic [31:0] words[$];
        logic [31:0] got, ra;
        logic [7:0]  s, x;
        a = 30'($urandom);
        for (int i = 0; i <= b; i++)
            words.push_back(directed ? ((i == 0) ? 32'hDEADBEEF : 32'hCAFEF00D) : $urandom);
        cq.delete();
        set_addr(a);
        io_wr(4, 8'(b));
        foreach (words[i]) rdq.push_back(words[i]);
        io_wr(12, 8'h02);
        wait_cmd();
        total++;
        if (cq.size() != 1) $display("FAIL rd_cmd_count: got %0d need 1", cq.size());
        else if (cq[0] !== {3'b001, 6'(b), a})
            $display("FAIL rd_cmd: got instr=%b bl=%0d addr=%h need 001 %0d %h", cq[0].instr, cq[0].bl, cq[0].addr, b, a);
        else passed++;
        for (int i = 0; i <= b; i++) begin
            s = 8'h00;
            for (int t = 0; t < 20 && !s[3]; t++) io_rd(13, s);
            total++;
            if (s !== exp_status(1'b1, 1'b1, 1'b0)) $display("FAIL rd_valid%0d: status %h need %h", i, s, exp_status(1'b1, 1'b1, 1'b0));
            else passed++;
            for (int l = 0; l < 4; l++) begin
                io_rd(8 + l, x);
                got[8*l +: 8] = x;
            end
            total++;
            if (got !== words[i]) $display("FAIL rd_word%0d: got %h need %h", i, got, words[i]); else passed++;
            io_rd(15, s);
            total++;
            if (s !== 8'(b - i)) $display("FAIL rd_rem%0d: got %0d need %0d", i, s, b - i); else passed++;
            io_wr(12, 8'h04);
        end
        idle(2);
        io_rd(13, s);
        total++;
        if (s !== exp_status(1'b0, 1'b0, 1'b0)) $display("FAIL rd_done_status: got %h need %h", s, exp_status(1'b0, 1'b0, 1'b0));
        else passed++;
        get_addr(ra);
        total++;
        if (ra !== {2'b00, next_addr(a, b)} || rdq.size() != 0)
            $display("FAIL rd_addr_adv: got %h need %h (left %0d words)", ra, next_addr(a, b), rdq.size());
        else passed++;
        cq.delete();
    endtask

    task automatic test_wr_err();
        logic [7:0] s;
        wq.delete(); cq.delete();
        set_addr(30'h0000_2000);
        io_wr(4, 8'd3);
        push_word($urandom); push_word($urandom);
        io_wr(12, 8'h01);
        idle(5);
        io_rd(13, s);
        total++;
        if (cq.size() != 0 || s !== exp_status(1'b0, 1'b0, 1'b1))
            $display("FAIL short_start: cmds %0d status %h need 0 and %h", cq.size(), s, exp_status(1'b0, 1'b0, 1'b1));
        else passed++;
        io_wr(12, 8'h80);
        io_rd(13, s);
        total++;
        if (s !== exp_status(1'b0, 1'b0, 1'b0)) $display("FAIL short_clr: status %h need %h", s, exp_status(1'b0, 1'b0, 1'b0));
        else passed++;
        push_word($urandom); push_word($urandom);
        io_wr(12, 8'h01);
        wait_cmd();
        total++;
        if (cq.size() != 1 || cq[0] !== {3'b000, 6'd3, 30'h0000_2000})
            $display("FAIL short_retry: %0d cmds, need one write at 2000", cq.size());
        else passed++;
        cq.delete();
    endtask

    task automatic test_cmd_full();
        logic [7:0] s;
        cq.delete();
        set_addr(30'h0000_0400);
        io_wr(4, 8'd0);
        push_word($urandom);
        cmd_full = 1'b1;
        io_wr(12, 8'h01);
        idle(5);
        io_rd(13, s);
        total++;
        if (cq.size() != 0 || s !== exp_status(1'b1, 1'b0, 1'b0))
            $display("FAIL cmd_full_hold: cmds %0d status %h need 0 and %h", cq.size(), s, exp_status(1'b1, 1'b0, 1'b0));
        else passed++;
        io_wr(12, 8'h01);
        io_rd(13, s);
        total++;
        if (s !== exp_status(1'b1, 1'b0, 1'b1)) $display("FAIL busy_start: status %h need %h", s, exp_status(1'b1, 1'b0, 1'b1));
        else passed++;
        cmd_full = 1'b0;
        wait_cmd();
        idle(3);
        total++;
        if (cq.size() != 1 || cq[0] !== {3'b000, 6'd0, 30'h0000_0400})
            $display("FAIL cmd_full_release: %0d cmds, need one write at 400", cq.size());
        else passed++;
        io_wr(12, 8'h80);
        cq.delete();
    endtask

    task automatic test_wr_full_pop();
        logic [7:0] s;
        wq.delete();
        wr_full = 1'b1;
        push_word($urandom);
        idle(3);
        io_rd(13, s);
        total++;
        if (wq.size() != 0 || s !== exp_status(1'b0, 1'b0, 1'b1))
            $display("FAIL wr_full_drop: pulses %0d status %h need 0 and %h", wq.size(), s, exp_status(1'b0, 1'b0, 1'b1));
        else passed++;
        wr_full = 1'b0;
        io_rd(14, s);
        total++;
        if (s !== 8'd0) $display("FAIL wr_full_cnt: got %0d need 0", s); else passed++;
        io_wr(12, 8'h80);
        io_wr(12, 8'h04);
        io_rd(13, s);
        total++;
        if (s !== exp_status(1'b0, 1'b0, 1'b1)) $display("FAIL pop_empty: status %h need %h", s, exp_status(1'b0, 1'b0, 1'b1));
        else passed++;
        io_wr(12, 8'h83);
        io_rd(13, s);
        total++;
        if (s !== exp_status(1'b0, 1'b0, 1'b1)) $display("FAIL both_starts: status %h need %h", s, exp_status(1'b0, 1'b0, 1'b1));
        else passed++;
        io_wr(12, 8'h80);
    endtask

    task automatic test_reset_mid();
        logic [7:0] s;
        logic [31:0] a;
        cq.delete();
        io_wr(4, 8'd1);
        rdq.push_back($urandom); rdq.push_back($urandom);
        io_wr(12, 8'h02);
        s = 8'h00;
        for (int t = 0; t < 20 && !s[3]; t++) io_rd(13, s);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        total++;
        if ({cmd_en, wr_en, rd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_data, in_port} !== '0 || s[3] !== 1'b1)
            $display("FAIL async_reset: cmd_en=%b wr_en=%b rd_en=%b in=%h held=%b need zeros after hold",
                     cmd_en, wr_en, rd_en, in_port, s[3]);
        else passed++;
        rdq.delete();
        idle(2);
        reset = 1'b1;
        io_rd(13, s);
        total++;
        if (s !== exp_status(1'b0, 1'b0, 1'b0)) $display("FAIL reset_mid_status: got %h need %h", s, exp_status(1'b0, 1'b0, 1'b0));
        else passed++;
        io_rd(15, s);
        get_addr(a);
        total++;
        if (s !== 8'd0 || a !== 32'd0) $display("FAIL reset_mid_regs: rem %0d addr %h need 0 0", s, a);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_calib();
        test_write_burst(30'h100, 3, 1'b1);
        test_read_burst(1, 1'b1);
        test_wr_err();
        test_cmd_full();
        test_write_burst(30'h3FFF_FFF8, 1, 1'b0);
        test_wr_full_pop();
        for (int k = 0; k < 3; k++) begin
            test_write_burst(30'($urandom), int'($urandom_range(0, 7)), 1'b0);
            test_read_burst(int'($urandom_range(0, 3)), 1'b0);
        end
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pico_mcb_bridge.md
# pico_mcb_bridge

Port-mapped bridge between the KCPSM6 8-bit I/O bus and one Spartan-6 MCB/LPDDR user port, with a hardware burst sequencer. Firmware stages write words byte-by-byte, programs address and burst length, and issues single-register start commands. The block drives the MCB command, write-FIFO and read-FIFO handshakes and exposes read words and status back on `in_port`. It sits between `kcpsm6` and the MIG wrapper, replacing per-signal firmware pulsing of `cmd_en`/`wr_en`/`rd_en`.

## Interface
- `DATA_W`, 32, MCB port data width; 8, 16 or 32. `NB = DATA_W/8` byte lanes.
- `ADDR_W`, 30, MCB byte-address width.
- `PORT_BASE`, 8'h20, base `port_id`; the block decodes `PORT_BASE..PORT_BASE+15`.
- `clk` in 1: single clock shared with KCPSM6 and the MCB user port.
- `reset` in 1: asynchronous, active-low.
- `port_id` in 8, `out_port` in 8, `write_strobe` in 1, `read_strobe` in 1: KCPSM6 I/O bus.
- `in_port` out 8: registered read-back data.
- `ddr_calib_done` in 1: MCB calibration complete.
- `cmd_en` out 1, `cmd_instr` out 3 (000 write, 001 read), `cmd_bl` out 6 (words−1), `cmd_byte_addr` out ADDR_W, `cmd_full` in 1.
- `wr_en` out 1, `wr_data` out DATA_W, `wr_mask` out NB (always 0), `wr_full` in 1, `wr_empty` in 1.
- `rd_en` out 1, `rd_data` in DATA_W, `rd_empty` in 1.

## Operation
- Register offsets from PORT_BASE. Write: 0–3 ADDR bytes (LSB first; bits ≥ADDR_W ignored); 4 BL (bits[5:0]); 8..8+NB−1 write-data lanes; 12 CTRL. Read: 8..8+NB−1 read-hold lanes; 13 STATUS; 14 pushed-word count; 15 read-word remaining count. Unmapped offsets read 0, writes ignored.
- Writing the top lane (8+NB−1) commits the staged word: if `wr_full`=0, pulse `wr_en` one cycle with staged data and increment `wr_cnt` (7 bit, saturates at 64); if `wr_full`=1, drop the word and set ERR.
- CTRL bits: [0] START_WR, [1] START_RD, [2] POP, [7] CLR_ERR. Only one start bit may be set; both set causes ERR with no action.
- FSM states: IDLE, WR_CMD, RD_CMD, RD_FETCH, RD_HOLD.
  - IDLE + START_WR: accepted only if `ddr_calib_done`=1 and `wr_cnt`==BL+1; otherwise set ERR and stay. Accepted: go to WR_CMD.
  - WR_CMD: wait for `cmd_full`=0, then pulse `cmd_en` with instr 000, `cmd_bl`=BL and the current ADDR. Clear `wr_cnt`, advance ADDR by (BL+1)·NB modulo 2^ADDR_W, return to IDLE.
  - IDLE + START_RD with calib done: go to RD_CMD and issue instr 001 in the same way; `rd_rem`←BL+1; go to RD_FETCH.
  - RD_FETCH: when `rd_empty`=0, pulse `rd_en`, capture `rd_data` into the hold register the same cycle, decrement `rd_rem`, set VALID, go to RD_HOLD.
  - RD_HOLD: POP clears VALID; go to RD_FETCH if `rd_rem`≠0, else advance ADDR and go to IDLE. POP with VALID=0 sets ERR.
- A start while not IDLE sets ERR and is ignored. Lane and ADDR writes while busy are allowed; the ADDR write takes effect for the next command.
- STATUS: [0] busy (state≠IDLE), [1] `ddr_calib_done`, [2] `wr_full`, [3] VALID, [4] ERR, [5] `wr_empty`, [6] `cmd_full`, [7] 0.

## Timing
- Writes are decoded at the `clk` edge where `write_strobe`=1. `in_port` is registered every cycle from `port_id`, so valid data appears 1 cycle after `port_id` (KCPSM6 holds it for 2).
- `wr_en` asserts the cycle after the committing strobe. `cmd_en` is a 1-cycle pulse, asserted the cycle after entering WR_CMD/RD_CMD if `cmd_full`=0.
- The hold register updates only on an `rd_en` cycle. `rd_en` is never asserted while VALID=1.
- Reset values: all outputs 0, `cmd_instr`=000, ADDR/BL/counters 0, ERR=0, VALID=0, state IDLE. Reset mid-burst abandons it; the MCB FIFOs are not flushed by this block.

## Test plan
- Write burst: ADDR=0x100, BL=3, commit 4 words (0x11223344…) -> 4 `wr_en` pulses, then START_WR gives one `cmd_en`, instr 000, bl=3, addr 0x100; ADDR reads back 0x110.
- Read burst: BL=1, START_RD, model returns 0xDEADBEEF, 0xCAFEF00D -> lane reads EF,BE,AD,DE; POP; next word; busy clears after the second POP.
- START_WR with only 2 of 4 words pushed -> no `cmd_en`, STATUS[4]=1; CLR_ERR clears it.
- START_RD before `ddr_calib_done` -> ERR set, no command; `cmd_full`=1 for 5 cycles -> `cmd_en` delayed until it drops.
- ADDR=2^30−8, BL=1, write -> `cmd_byte_addr`=2^30−8, ADDR wraps to 0.
- `reset` low during RD_HOLD -> all outputs 0, IDLE, VALID=0 asynchronously.
